// File: rtl/commu_pkg.sv
// Shared constants and types for the commu line receiver.
// Holds the state encoding, word/counter widths and the period clamp helper.
package commu_pkg;

  localparam int   COMMU_DW         = 16;
  localparam int   COMMU_MIN_PERIOD = 4;
  localparam int   COMMU_CNT_W      = 20;
  localparam int   COMMU_IDX_W      = 5;
  localparam logic COMMU_IDLE_LVL   = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } commu_state_e;

  function automatic logic [COMMU_CNT_W-1:0] commu_clamp_period(
    input logic [COMMU_CNT_W-1:0] p,
    input logic [COMMU_CNT_W-1:0] pmin
  );
    return (p < pmin) ? pmin : p;
  endfunction

endpackage

// File: rtl/commu_sync.sv
// Multi-flop synchronizer for the asynchronous rx line.
// Resets to the line idle level so a reset never looks like a start bit.
module commu_sync
  import commu_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk_sys) begin
    if (rst) r_ff <= {STAGES{COMMU_IDLE_LVL}};
    else     r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/commu_rx_word.sv
// Serial word receiver: start + DW data bits (MSB first) + stop, bit time set by tbit_period.
// Emits a one-cycle rx_vld with the word, or a one-cycle rx_err on a framing error.
module commu_rx_word
  import commu_pkg::*;
#(
  parameter int DW          = COMMU_DW,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = COMMU_MIN_PERIOD
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   en,
  input  logic [COMMU_CNT_W-1:0] tbit_period,
  output logic [DW-1:0]          rx_data,
  output logic                   rx_vld,
  output logic                   rx_err,
  output logic                   rx_busy
);

  logic w_rxs;
  logic w_fall;
  logic [COMMU_CNT_W-1:0] w_period;
  logic [COMMU_CNT_W-1:0] w_half_m1;

  commu_state_e           r_state;
  logic                   r_rxs_d;
  logic [COMMU_CNT_W-1:0] r_period;
  logic [COMMU_CNT_W-1:0] r_cnt;
  logic [COMMU_IDX_W-1:0] r_idx;
  logic [DW-1:0]          r_shift;
  logic [DW-1:0]          r_data;
  logic                   r_vld;
  logic                   r_err;

  commu_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  assign w_fall    = r_rxs_d & ~w_rxs;
  assign w_period  = commu_clamp_period(tbit_period, COMMU_CNT_W'(MIN_PERIOD));
  // First sample lands half a bit after the edge; counter reaches 0 on the sample cycle.
  assign w_half_m1 = (w_period >> 1) - COMMU_CNT_W'(1);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rxs_d  <= COMMU_IDLE_LVL;
      r_period <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rxs_d <= w_rxs;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_fall) begin
              r_period <= w_period;
              r_cnt    <= w_half_m1;
              r_state  <= START;
            end
          end
          START: begin
            if (r_cnt == '0) begin
              if (w_rxs) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_cnt   <= r_period - COMMU_CNT_W'(1);
                r_idx   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - COMMU_CNT_W'(1);
            end
          end
          DATA: begin
            if (r_cnt == '0) begin
              r_shift <= {r_shift[DW-2:0], w_rxs};
              r_cnt   <= r_period - COMMU_CNT_W'(1);
              if (r_idx == COMMU_IDX_W'(DW-1)) r_state <= STOP;
              else                             r_idx   <= r_idx + COMMU_IDX_W'(1);
            end else begin
              r_cnt <= r_cnt - COMMU_CNT_W'(1);
            end
          end
          STOP: begin
            if (r_cnt == '0) begin
              if (w_rxs) begin
                r_data  <= r_shift;
                r_vld   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= WAIT_HI;
              end
            end else begin
              r_cnt <= r_cnt - COMMU_CNT_W'(1);
            end
          end
          // Break holds the line low; wait for idle so no false start is seen.
          WAIT_HI: begin
            if (w_rxs) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_data = r_data;
  assign rx_vld  = r_vld;
  assign rx_err  = r_err;
  assign rx_busy = (r_state != IDLE);

endmodule

// File: tb/tb_commu_rx_word.sv
// Directed bench for commu_rx_word: a line driver feeds framed words, a scoreboard
// queue holds the words expected on rx_vld, and a monitor pops and compares them.
module tb_commu_rx_word;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        rx;
  logic        en;
  logic [19:0] tbit_period;
  logic [15:0] rx_data;
  logic        rx_vld;
  logic        rx_err;
  logic        rx_busy;

  int errors = 0;
  int checks = 0;
  int n_vld  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int fall_cyc = 0;
  int vld_cyc  = 0;
  logic [15:0] exp_q[$];

  commu_rx_word dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx          (rx),
    .en          (en),
    .tbit_period (tbit_period),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .rx_err      (rx_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every rx_vld pops one expected word.
  always @(negedge clk_sys) begin
    if (rst === 1'b0) begin
      if (rx_vld === 1'b1) begin
        n_vld++;
        vld_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_vld", {16'h0, rx_data}, 32'hFFFF_FFFF);
        else                   chk("rx_data", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
      end
      if (rx_err === 1'b1) n_err++;
      if (rx_vld === 1'b1 && rx_err === 1'b1) chk("vld_and_err", 1, 0);
    end
  end

  // Drives bits[n-1] first, each for p cycles; call on a negedge.
  task automatic drive_bits(input logic [31:0] bits, input int n, input int p);
    for (int i = n - 1; i >= 0; i--) begin
      rx = bits[i];
      repeat (p) @(negedge clk_sys);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int p);
    fall_cyc = cyc;
    drive_bits({14'b0, 1'b0, w, 1'b1}, 18, p);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_sys);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b1; tbit_period = 20'd10;
    repeat (3) @(negedge clk_sys);
    chk("rst_data", {16'h0, rx_data}, 0);
    chk("rst_vld",  rx_vld,  0);
    chk("rst_err",  rx_err,  0);
    chk("rst_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);

    // Clean word; pulse lands in cycle 3+5+170+1 counting the pin-fall cycle as 1.
    exp_q.push_back(16'hA55A);
    send_word(16'hA55A, 10);
    repeat (5) @(negedge clk_sys);
    wait_drain();
    chk("latency", vld_cyc - fall_cyc + 1, 3 + 5 + 170 + 1);
    chk("n_vld_1", n_vld, 1);
    chk("n_err_1", n_err, 0);

    // Back-to-back words, no idle gap.
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hFFFE);
    send_word(16'h0001, 10);
    send_word(16'hFFFE, 10);
    repeat (5) @(negedge clk_sys);
    wait_drain();
    chk("n_vld_b2b", n_vld, 3);

    // Framing error followed by a 50-bit break.
    drive_bits({14'b0, 1'b0, 16'h5A5A, 1'b0}, 18, 10);
    repeat (500) @(negedge clk_sys);
    chk("brk_busy", rx_busy, 1);
    chk("brk_err",  n_err, 1);
    chk("brk_vld",  n_vld, 3);
    chk("brk_data", {16'h0, rx_data}, 32'hFFFE);
    rx = 1'b1;
    repeat (6) @(negedge clk_sys);
    chk("brk_idle", rx_busy, 0);
    chk("brk_err2", n_err, 1);

    // Short glitch must be rejected at the start check.
    rx = 1'b0;
    repeat (3) @(negedge clk_sys);
    rx = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("glitch_busy", rx_busy, 0);
    chk("glitch_cnt", n_vld + n_err, 4);
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 10);
    repeat (5) @(negedge clk_sys);
    wait_drain();

    // Clamped period, then a period change mid-word.
    tbit_period = 20'd2;
    exp_q.push_back(16'hC3C3);
    send_word(16'hC3C3, 4);
    repeat (5) @(negedge clk_sys);
    tbit_period = 20'd10;
    exp_q.push_back(16'h0F0F);
    fork
      send_word(16'h0F0F, 10);
      begin repeat (60) @(negedge clk_sys); tbit_period = 20'd20; end
    join
    repeat (5) @(negedge clk_sys);
    wait_drain();
    exp_q.push_back(16'h6C93);
    send_word(16'h6C93, 20);
    repeat (5) @(negedge clk_sys);
    wait_drain();
    chk("n_vld_per", n_vld, 7);
    tbit_period = 20'd10;

    // Disable mid-word.
    drive_bits(32'b01010, 5, 10);
    en = 1'b0;
    @(negedge clk_sys);
    chk("en_busy", rx_busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk_sys);
    en = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("en_cnt", n_vld + n_err, 8);

    // Reset at data bit 8.
    drive_bits({23'b0, 1'b0, 8'hBE}, 9, 10);
    rx = 1'b1;
    repeat (5) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_busy", rx_busy, 0);
    chk("rst_mid_data", {16'h0, rx_data}, 0);
    chk("rst_mid_vld",  rx_vld, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk_sys);
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 10);
    repeat (5) @(negedge clk_sys);
    wait_drain();
    chk("n_vld_end", n_vld, 8);
    chk("n_err_end", n_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commu_rx_word.md
Name: commu_rx_word

Overview:
- Line-side receiver, directly downstream of the device transmit path; consumes the serial stream that the device puts on tx_a/tx_b.
- Recovers each 16-bit word (head, push data, tail) and delivers it to the master-side frame assembler as a one-cycle-valid parallel word.
- Line format, fixed for the commu link:
  - Idle level is 1.
  - 1 start bit (0), then 16 data bits MSB first, then 1 stop bit (1).
  - Each bit lasts tbit_period clk_sys cycles.

Parameters:
- DW, 16, data bits per word.
- SYNC_STAGES, 2, synchronizer flops on rx (minimum 2).
- MIN_PERIOD, 4, lower clamp applied to tbit_period.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line input (idle 1).
- en  in  1  receiver enable; 0 forces IDLE at the next edge and suppresses all outputs.
- tbit_period  in  20  bit time in clk_sys cycles.
- rx_data  out  DW  last received word; holds its value until the next good word.
- rx_vld  out  1  one-cycle pulse, high the cycle rx_data updates.
- rx_err  out  1  one-cycle pulse on a stop-bit (framing) error.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Applies on any clk_sys edge with rst=1; mid-frame it aborts the word with no pulse.
  - State=IDLE; synchronizer flops=1; rx_data=0; rx_vld=0; rx_err=0; rx_busy=0; counters=0.
- Input path:
  - rx passes SYNC_STAGES flops to give rxs, then one more flop to give rxs_d.
  - Start detection is the falling edge rxs_d=1, rxs=0.
- Period latch:
  - On start detection, P = max(tbit_period, MIN_PERIOD) is latched.
  - A tbit_period change mid-word has no effect until the next start.
- Timing: t0 is the cycle the falling edge is detected; H = P>>1 (floor).
  - Start-bit check at t0+H.
  - Data bit i (i=0 is MSB) sampled at t0+H+(i+1)*P.
  - Stop bit sampled at t0+H+(DW+1)*P.
- States:
  - IDLE: on falling edge and en=1, go to START. The bit counter is loaded with H-1 and counts down to 0.
  - START: at the sample point:
    - rxs=1: glitch; return to IDLE with no pulse.
    - rxs=0: go to DATA; bit counter=P-1; idx=0.
  - DATA: at each sample point, shift rxs into a DW-bit shift register (LSB in, so the MSB arrives first). When idx=DW-1 goes to STOP; otherwise idx+1.
  - STOP: at the sample point:
    - rxs=1: rx_data<=shift register and rx_vld=1 for one cycle (the cycle after the sample point); go to IDLE.
    - rxs=0: rx_err=1 for one cycle; rx_data unchanged; go to WAIT_HI.
  - WAIT_HI: stay until rxs=1, then go to IDLE. A held-low break therefore produces exactly one rx_err and never a false start.
- Back-to-back words:
  - IDLE is re-entered right after the stop sample.
  - The next falling edge may be detected in the same cycle IDLE is entered, so there is no dead time.
- en=0 in any state: go to IDLE at the next edge, no pulses. rx_data keeps its value.
- rx_vld and rx_err are never high in the same cycle.
- Counters:
  - Bit counter is 20 bits and idx is 5 bits; neither wraps in legal operation.
  - The count-down reload reaches 0 exactly at each sample point.
- End-to-end latency, pin to rx_vld: SYNC_STAGES+1 cycles of detection + H + (DW+1)*P + 1 cycles.

Decomposition:
- Shared package commu_pkg holds:
  - state encoding constants: IDLE, START, DATA, STOP, WAIT_HI;
  - COMMU_DW=16;
  - COMMU_MIN_PERIOD=4;
  - the line idle level constant.
- One sub-module, commu_sync: a SYNC_STAGES-deep synchronizer with reset value 1.
- The FSM, counters and shift register stay in commu_rx_word.

Test Plan:
- Word 16'hA55A sent with tbit_period=10 on a clean line -> one rx_vld; rx_data=16'hA55A; rx_vld occurs 3+5+170+1 cycles after the falling edge at the pin; rx_err stays 0.
- Words 16'h0001 and 16'hFFFE sent back-to-back with zero idle between them, P=10 -> two rx_vld pulses with rx_data 0001 then FFFE.
- Stop bit forced to 0, then line held low for 50 bit times -> one rx_err pulse, no rx_vld, rx_data still shows the previous word, rx_busy stays high until rx returns to 1.
- 3-cycle low glitch with P=10 -> back in IDLE at the start check, no pulses; a following valid 16'h1234 is received correctly.
- tbit_period=2 (clamped to 4) sending 16'hC3C3, and tbit_period changed from 10 to 20 mid-word -> both words decode correctly using the period latched at their start.
- rst=1 asserted at data bit 8 of a word -> at the next edge rx_busy=0, rx_data=0, no rx_vld; the next full word decodes normally.
